// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store, load-check and memory write-port bundle for store_buffer
//
// Purpose: groups the core-facing store/load handshake and the memory-facing
// write port of the store buffer into one bundle.
// Signals:
//   st_valid/st_ready/st_addr/st_data/st_size  store push handshake
//   ld_valid/ld_addr/ld_hazard                 load-versus-pending-store check
//   mem_hold/mem_write/mem_addr/mem_wdata/mem_size  drain to data_memory
// Modports:
//   master  core/memory side (drives stores, loads and mem_hold)
//   slave   store buffer side
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [1:0]    st_size;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;

  logic          mem_hold;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_size;

  modport master (
    output st_valid, st_addr, st_data, st_size,
    input  st_ready,
    output ld_valid, ld_addr,
    input  ld_hazard,
    output mem_hold,
    input  mem_write, mem_addr, mem_wdata, mem_size
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size,
    output st_ready,
    input  ld_valid, ld_addr,
    output ld_hazard,
    input  mem_hold,
    output mem_write, mem_addr, mem_wdata, mem_size
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO write buffer between the store path and data_memory
//
// Purpose: queues stores (address, data, size) and drains one per cycle into
// the data_memory write port, in push order. Loads whose address matches any
// pending store raise ld_hazard so the pipeline stalls instead of reading
// stale memory.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; discards all pending stores
//   bus       store_buffer_if.slave (store push, load check, memory port)
//   count     occupied entries, $clog2(DEPTH)+1 bits
//   empty     no pending stores
//   full      count == DEPTH; st_ready is low
//   err_size  sticky flag: a reserved store size (2'b11) was presented
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  store_buffer_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     err_size
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  logic [AW-1:0] addr_q  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [1:0]    size_q  [DEPTH];
  logic          valid_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic          is_empty;
  logic          is_full;
  logic          accept;
  logic          push;
  logic          pop;
  logic          hazard;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // A store is accepted on the handshake; reserved sizes are accepted (so the
  // core does not hang) but never enqueued.
  assign accept = bus.st_valid && !is_full;
  assign push   = accept && (bus.st_size != SIZE_RSVD);
  // Pop coincides with the memory sampling the write at this edge.
  assign pop    = !is_empty && !bus.mem_hold;

  // Hazard scan over every valid entry, head included even when it pops in
  // this cycle; the store on st_* this cycle is deliberately not compared.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.ld_addr)) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        size_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      // A pop and a push never target the same slot in one cycle: a push
      // needs !full, so wr_ptr differs from rd_ptr whenever both happen.
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        addr_q[wr_ptr]  <= bus.st_addr;
        data_q[wr_ptr]  <= bus.st_data;
        size_q[wr_ptr]  <= bus.st_size;
        valid_q[wr_ptr] <= 1'b1;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && (bus.st_size == SIZE_RSVD)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.st_ready  = !is_full;
  assign bus.ld_hazard = bus.ld_valid && hazard;
  assign bus.mem_write = pop;
  assign bus.mem_addr  = is_empty ? '0 : addr_q[rd_ptr];
  assign bus.mem_wdata = is_empty ? '0 : data_q[rd_ptr];
  assign bus.mem_size  = is_empty ? '0 : size_q[rd_ptr];

  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign err_size = err_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard testbench for store_buffer
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    size;
  } st_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       err_size;

  int  n_checks = 0;
  int  n_fail   = 0;
  st_t sb[$];
  bit  exp_err  = 1'b0;
  logic [DW-1:0] mem [64];

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err_size (err_size)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_store(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] s);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
  endtask

  // One clock: check DUT against the model at the negedge, update the model
  // for the coming posedge, return 1 ns after that posedge.
  task automatic cycle();
    bit exp_ready, exp_write, exp_haz, push, pop;
    @(negedge clk);
    exp_ready = (sb.size() < DEPTH);
    exp_write = (sb.size() != 0) && !bus.mem_hold;
    exp_haz   = 1'b0;
    if (bus.ld_valid) foreach (sb[i]) if (sb[i].addr == bus.ld_addr) exp_haz = 1'b1;
    check("count", count, sb.size());
    check("empty", empty, sb.size() == 0);
    check("full", full, sb.size() == DEPTH);
    check("st_ready", bus.st_ready, exp_ready);
    check("mem_write", bus.mem_write, exp_write);
    check("ld_hazard", bus.ld_hazard, exp_haz);
    check("err_size", err_size, exp_err);
    if (sb.size() != 0) begin
      check("mem_addr", bus.mem_addr, sb[0].addr);
      check("mem_wdata", bus.mem_wdata, sb[0].data);
      check("mem_size", bus.mem_size, sb[0].size);
    end else begin
      check("mem_addr_idle", bus.mem_addr, 0);
    end
    pop  = exp_write;
    push = bus.st_valid && exp_ready && (bus.st_size != 2'b11);
    if (bus.st_valid && exp_ready && bus.st_size == 2'b11) exp_err = 1'b1;
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back({bus.st_addr, bus.st_data, bus.st_size});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_store(1'b0, '0, '0, 2'b10);
    bus.mem_hold = 1'b0;
    for (int i = 0; i < 2 * DEPTH + 4 && sb.size() != 0; i++) cycle();
    #1;
    check("drain_empty", empty, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_err = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_err", err_size, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.mem_hold = 1'b0;
    set_store(1'b1, 32'd7, 32'h1234, 2'b10);

    // 1: reset held with st_valid high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_rst_count", count, 0);
    check("hold_rst_empty", empty, 1);
    check("hold_rst_mem_write", bus.mem_write, 0);
    rst_n = 1'b1;
    set_store(1'b0, '0, '0, 2'b10);
    @(posedge clk);
    #1;

    // 1b: reset mid-drain with 3 queued
    bus.mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'd20 + i, 32'hC0 + i, 2'b10);
      cycle();
    end
    set_store(1'b0, '0, '0, 2'b10);
    bus.mem_hold = 1'b0;
    cycle();
    do_reset();

    // 2: single word store
    set_store(1'b1, 32'd5, 32'hDEADBEEF, 2'b10);
    cycle();
    set_store(1'b0, '0, '0, 2'b10);
    #1;
    check("t2_mem_write", bus.mem_write, 1);
    check("t2_mem_addr", bus.mem_addr, 5);
    check("t2_mem_size", bus.mem_size, 2'b10);
    cycle();
    #1;
    check("t2_memory5", mem[5], 32'hDEADBEEF);
    check("t2_empty", empty, 1);

    // 3: fill with hold, fifth dropped, drain, then wrap
    bus.mem_hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_store(1'b1, i, 32'hA0 + i, 2'b10);
      cycle();
    end
    #1;
    check("t3_full", full, 1);
    check("t3_st_ready", bus.st_ready, 0);
    drain();
    for (int i = 1; i <= 4; i++) check($sformatf("t3_mem%0d", i), mem[i], 32'hA0 + i);
    check("t3_mem5_kept", mem[5], 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      set_store(1'b1, 32'd40 + i, $urandom, 2'b10);
      cycle();
    end
    drain();

    // 4: push and pop in the same cycle at count 2
    bus.mem_hold = 1'b1;
    set_store(1'b1, 32'd50, 32'h50, 2'b10);
    cycle();
    set_store(1'b1, 32'd51, 32'h51, 2'b10);
    cycle();
    bus.mem_hold = 1'b0;
    set_store(1'b1, 32'd52, 32'h52, 2'b10);
    cycle();
    #1;
    check("t4_count", count, 2);
    drain();
    check("t4_mem52", mem[52], 32'h52);

    // 5: load hazard
    bus.mem_hold = 1'b1;
    set_store(1'b1, 32'd9, 32'h99, 2'b10);
    cycle();
    set_store(1'b0, '0, '0, 2'b10);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'd9;
    #1;
    check("t5_hazard9", bus.ld_hazard, 1);
    cycle();
    bus.ld_addr = 32'd8;
    #1;
    check("t5_hazard8", bus.ld_hazard, 0);
    cycle();
    bus.ld_addr = 32'd9;
    drain();
    check("t5_hazard_after", bus.ld_hazard, 0);
    bus.ld_valid = 1'b0;

    // 6: byte, half and reserved sizes
    set_store(1'b1, 32'd30, 32'h11223344, 2'b00);
    cycle();
    set_store(1'b1, 32'd31, 32'h5566, 2'b01);
    #1;
    check("t6_byte_size", bus.mem_size, 2'b00);
    cycle();
    set_store(1'b1, 32'd32, 32'h77, 2'b11);
    cycle();
    set_store(1'b0, '0, '0, 2'b10);
    #1;
    check("t6_err_set", err_size, 1);
    drain();
    check("t6_rsvd_not_written", mem[32], 0);
    repeat (3) cycle();
    check("t6_err_sticky", err_size, 1);
    do_reset();
    check("t6_err_cleared", err_size, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
